// File: rtl/wb_pkg.sv
// Shared constants and the queued writeback entry type for the regfile writeback controller.
package wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] wa;
    logic [REG_DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending LSU/MDU writebacks; queued entries can be squashed by address so a
// younger ALU write to the same register is never overwritten by an older long-latency result.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  input  logic                        squash,
  input  logic [REG_AW-1:0]           squash_wa,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        empty,
  output logic                        full
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [PW-1:0] PTR_MASK = PW'(FIFO_DEPTH - 1);

  wb_entry_t         entries_q [FIFO_DEPTH];
  wb_entry_t         entries_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;

  assign head  = entries_q[rd_ptr_q];
  assign level = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(FIFO_DEPTH));

  always_comb begin
    entries_d = entries_q;
    // Squash only touches stored entries; a same-cycle push arrives with live already resolved.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (squash && entries_q[i].wa == squash_wa) begin
        entries_d[i].live = 1'b0;
      end
    end
    if (push) begin
      entries_d[wr_ptr_q] = push_entry;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ((wr_ptr_q + 1'b1) & PTR_MASK) : wr_ptr_q;
    rd_ptr_d = pop  ? ((rd_ptr_q + 1'b1) & PTR_MASK) : rd_ptr_q;
    count_d  = count_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port arbiter: ALU results win every cycle, LSU/MDU results drain from a FIFO.
// Optional pending-write scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_AW     = wb_pkg::REG_AW,
  parameter int unsigned REG_DW     = wb_pkg::REG_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [REG_AW-1:0]           alu_wa,
  input  logic [REG_DW-1:0]           alu_wd,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [REG_AW-1:0]           lsu_wa,
  input  logic [REG_DW-1:0]           lsu_wd,
  output logic                        we,
  output logic [REG_AW-1:0]           wa,
  output logic [REG_DW-1:0]           wd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        sb_set,
  input  logic [REG_AW-1:0]           sb_addr,
  output logic [31:0]                 busy
);

  import wb_pkg::*;

  logic              alu_live;
  logic              lsu_fire;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  wb_entry_t         push_entry;
  wb_entry_t         head;

  logic              we_q, we_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [REG_DW-1:0] wd_q, wd_d;

  assign alu_live  = alu_valid && (alu_wa != '0);
  assign lsu_ready = !rst && !fifo_full;
  assign lsu_fire  = lsu_valid && lsu_ready;
  // Writes to r0 complete the handshake but are never queued.
  assign push      = lsu_fire && (lsu_wa != '0);
  assign pop       = !alu_live && !fifo_empty;

  always_comb begin
    push_entry.live = !(alu_live && (alu_wa == lsu_wa));
    push_entry.wa   = lsu_wa;
    push_entry.wd   = lsu_wd;
  end

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .squash     (alu_live),
    .squash_wa  (alu_wa),
    .level      (fifo_level),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (alu_live) begin
      we_d = 1'b1;
      wa_d = alu_wa;
      wd_d = alu_wd;
    end else if (pop) begin
      we_d = head.live;
      wa_d = head.wa;
      wd_d = head.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clear precedes set so a same-cycle reissue keeps the register pending.
    if (we_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (sb_set) begin
      busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_sb;
  assign unused_sb = sb_set ^ (^sb_addr);
  assign busy      = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (FIFO_DEPTH=4).
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  fifo_level;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_ctrl #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_wa     (alu_wa),
    .alu_wd     (alu_wd),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_wa     (lsu_wa),
    .lsu_wd     (lsu_wd),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .fifo_level (fifo_level),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we got %0b want 0", we); end
    n_cmp++; if (wa !== 5'd0 || wd !== 32'd0) begin
      n_err++; $display("FAIL rst_wa_wd got %0d/%h want 0/0", wa, wd);
    end
    n_cmp++; if (lsu_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_ready got %0b want 0", lsu_ready);
    end
    n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL rst_busy got %h want 0", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (lsu_ready !== 1'b1) begin
      n_err++; $display("FAIL rel_ready got %0b want 1", lsu_ready);
    end
    n_cmp++; if (fifo_level !== 3'd0) begin
      n_err++; $display("FAIL rel_level got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'h1234;
    step();
    idle_inputs();
    n_cmp++; if (we !== 1'b1 || wa !== 5'd3 || wd !== 32'h1234) begin
      n_err++; $display("FAIL alu_write got %0b/%0d/%h want 1/3/1234", we, wa, wd);
    end
    step();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL alu_idle got %0b want 0", we); end
  endtask

  task automatic test_merge();
    alu_valid = 1'b1; alu_wa = 5'd4; alu_wd = 32'h11;
    lsu_valid = 1'b1; lsu_wa = 5'd5; lsu_wd = 32'h22;
    step();
    idle_inputs();
    n_cmp++; if (we !== 1'b1 || wa !== 5'd4 || wd !== 32'h11 || fifo_level !== 3'd1) begin
      n_err++;
      $display("FAIL merge_alu got %0b/%0d/%h lvl %0d want 1/4/11 lvl 1", we, wa, wd, fifo_level);
    end
    step();
    n_cmp++; if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'h22 || fifo_level !== 3'd0) begin
      n_err++;
      $display("FAIL merge_lsu got %0b/%0d/%h lvl %0d want 1/5/22 lvl 0", we, wa, wd, fifo_level);
    end
    step();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL merge_idle got %0b want 0", we); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_wa = 5'(i); alu_wd = 32'(i * 16);
      lsu_valid = 1'b1; lsu_wa = 5'(10 + i); lsu_wd = 32'h100 + 32'(i);
      step();
      n_cmp++; if (we !== 1'b1 || wa !== 5'(i) || wd !== 32'(i * 16)) begin
        n_err++; $display("FAIL full_alu%0d got %0b/%0d/%h want 1/%0d/%h", i, we, wa, wd, i, i * 16);
      end
    end
    n_cmp++; if (fifo_level !== 3'd4 || lsu_ready !== 1'b0) begin
      n_err++; $display("FAIL full_level got %0d rdy %0b want 4 rdy 0", fifo_level, lsu_ready);
    end
    // Full and popping this cycle: the offered result must still be refused.
    alu_valid = 1'b0; lsu_wa = 5'd20; lsu_wd = 32'hDEAD;
    step();
    lsu_valid = 1'b0;
    n_cmp++; if (we !== 1'b1 || wa !== 5'd11 || wd !== 32'h101 || fifo_level !== 3'd3) begin
      n_err++;
      $display("FAIL full_pop1 got %0b/%0d/%h lvl %0d want 1/11/101 lvl 3", we, wa, wd, fifo_level);
    end
    n_cmp++; if (lsu_ready !== 1'b1) begin
      n_err++; $display("FAIL full_ready_back got %0b want 1", lsu_ready);
    end
    for (int i = 2; i <= 4; i++) begin
      step();
      n_cmp++; if (we !== 1'b1 || wa !== 5'(10 + i) || wd !== 32'h100 + 32'(i)) begin
        n_err++; $display("FAIL full_pop%0d got %0b/%0d/%h want 1/%0d/%h", i, we, wa, wd,
                          10 + i, 32'h100 + 32'(i));
      end
    end
    n_cmp++; if (fifo_level !== 3'd0) begin
      n_err++; $display("FAIL full_drained got %0d want 0", fifo_level);
    end
    step();
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL full_idle got %0b want 0", we); end
  endtask

  task automatic test_squash();
    alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 32'h1;
    lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'hBB;
    step();
    lsu_valid = 1'b0;
    alu_wa = 5'd7; alu_wd = 32'hAA;
    step();
    alu_valid = 1'b0;
    n_cmp++; if (we !== 1'b1 || wa !== 5'd7 || wd !== 32'hAA || fifo_level !== 3'd1) begin
      n_err++;
      $display("FAIL sq_alu got %0b/%0d/%h lvl %0d want 1/7/AA lvl 1", we, wa, wd, fifo_level);
    end
    step();
    n_cmp++; if (we !== 1'b0 || fifo_level !== 3'd0) begin
      n_err++; $display("FAIL sq_dead_pop got we %0b lvl %0d want 0 lvl 0", we, fifo_level);
    end
    // Same-cycle push to the register the ALU is writing is enqueued dead.
    alu_valid = 1'b1; alu_wa = 5'd8; alu_wd = 32'hCC;
    lsu_valid = 1'b1; lsu_wa = 5'd8; lsu_wd = 32'hDD;
    step();
    idle_inputs();
    n_cmp++; if (we !== 1'b1 || wa !== 5'd8 || wd !== 32'hCC || fifo_level !== 3'd1) begin
      n_err++;
      $display("FAIL sq_same_alu got %0b/%0d/%h lvl %0d want 1/8/CC lvl 1", we, wa, wd, fifo_level);
    end
    step();
    n_cmp++; if (we !== 1'b0 || fifo_level !== 3'd0) begin
      n_err++; $display("FAIL sq_same_pop got we %0b lvl %0d want 0 lvl 0", we, fifo_level);
    end
  endtask

  task automatic test_r0_and_scoreboard();
    logic exp_b;
    alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hBEEF;
    lsu_valid = 1'b1; lsu_wa = 5'd9; lsu_wd = 32'h99;
    step();
    lsu_valid = 1'b0;
    n_cmp++; if (we !== 1'b0 || fifo_level !== 3'd1) begin
      n_err++; $display("FAIL r0_push got we %0b lvl %0d want 0 lvl 1", we, fifo_level);
    end
    sb_set = 1'b1; sb_addr = 5'd9;
    step();
    sb_set = 1'b0;
    n_cmp++; if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'h99) begin
      n_err++; $display("FAIL r0_alu_pop got %0b/%0d/%h want 1/9/99", we, wa, wd);
    end
`ifdef WB_SCOREBOARD_EN
    exp_b = 1'b1;
`else
    exp_b = 1'b0;
`endif
    n_cmp++; if (busy[9] !== exp_b) begin
      n_err++; $display("FAIL sb_set9 got %0b want %0b", busy[9], exp_b);
    end
    alu_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 32'd0) begin
      n_err++; $display("FAIL sb_clear9 got %h want 0", busy);
    end
    // Set coincides with the clear of the same register: set wins.
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h5;
    step();
    alu_valid = 1'b0; sb_set = 1'b1; sb_addr = 5'd9;
    step();
    sb_set = 1'b0;
    n_cmp++; if (busy[9] !== exp_b) begin
      n_err++; $display("FAIL sb_set_wins got %0b want %0b", busy[9], exp_b);
    end
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    sb_set = 1'b0;
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL sb_r0 got %0b want 0", busy[0]); end
    lsu_valid = 1'b1; lsu_wa = 5'd0; lsu_wd = 32'h77;
    #1;
    n_cmp++; if (lsu_ready !== 1'b1) begin
      n_err++; $display("FAIL r0_lsu_ready got %0b want 1", lsu_ready);
    end
    step();
    lsu_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd0 || we !== 1'b0) begin
      n_err++; $display("FAIL r0_lsu_drop got lvl %0d we %0b want 0/0", fifo_level, we);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_wa = 5'd2; alu_wd = 32'h2;
      lsu_valid = 1'b1; lsu_wa = 5'(12 + i); lsu_wd = 32'h3;
      step();
    end
    n_cmp++; if (fifo_level !== 3'd2) begin
      n_err++; $display("FAIL mid_level got %0d want 2", fifo_level);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    n_cmp++; if (fifo_level !== 3'd0 || we !== 1'b0 || lsu_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst got lvl %0d we %0b rdy %0b want 0/0/0", fifo_level, we,
                        lsu_ready);
    end
    rst = 1'b0;
    step();
    n_cmp++; if (we !== 1'b0 || fifo_level !== 3'd0) begin
      n_err++; $display("FAIL mid_after got we %0b lvl %0d want 0/0", we, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_merge();
    test_full();
    test_squash();
    test_r0_and_scoreboard();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
